// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage and its pipeline registers.
// INST_ALIGN_CHECK_EN adds an address-error flag to the IF/ID payload.
package inst_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam logic  CHIP_ENABLE  = 1'b1;
  localparam logic  CHIP_DISABLE = 1'b0;
  localparam addr_t ZERO_WORD    = 32'h0000_0000;
  localparam inst_t NOP_ENC      = 32'h0000_0000;
  localparam addr_t RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    addr_t pc;
    inst_t inst;
    logic  valid;
`ifdef INST_ALIGN_CHECK_EN
    logic  excp_adel;
`endif
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load.
// Reset and flush both leave a bubble (zero fields, NOP instruction).
module if_id_reg
  import inst_fetch_pkg::*;
#(
  parameter inst_t NOP_INST = NOP_ENC
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= '0;
      q.inst <= NOP_INST;
    end else if (flush) begin
      q      <= '0;
      q.inst <= NOP_INST;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, ROM request port and IF/ID register.
// INST_ALIGN_CHECK_EN adds id_excp_adel and gates the ROM on misaligned PCs.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_VECTOR,
  parameter addr_t PC_STEP  = 32'd4,
  parameter inst_t NOP_INST = NOP_ENC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  branch_flag,
  input  addr_t branch_target,
  input  logic  flush,
  input  addr_t new_pc,
  output logic  rom_en,
  output addr_t rom_addr,
  input  inst_t rom_inst,
  output addr_t id_pc,
  output inst_t id_inst,
  output logic  id_valid
`ifdef INST_ALIGN_CHECK_EN
  ,
  output logic  id_excp_adel
`endif
);

  logic   rom_en_r;
  addr_t  pc;
  logic   misaligned;
  if_id_t if_d;
  if_id_t if_q;

  // Enable ramps one edge after reset release; PC is frozen until then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rom_en_r <= CHIP_DISABLE;
    else      rom_en_r <= CHIP_ENABLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (rom_en_r == CHIP_ENABLE) begin
      if (flush)            pc <= new_pc;
      else if (!stall) begin
        if (branch_flag)    pc <= branch_target;
        else                pc <= pc + PC_STEP;
      end
    end
  end

`ifdef INST_ALIGN_CHECK_EN
  assign misaligned = |pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign rom_en   = rom_en_r & ~misaligned;
  assign rom_addr = pc;

  // A misaligned fetch still occupies a valid slot so the exception reaches commit.
  always_comb begin
    if_d       = '0;
    if_d.pc    = ZERO_WORD;
    if_d.inst  = NOP_INST;
    if_d.valid = 1'b0;
    if (rom_en_r == CHIP_ENABLE) begin
      if_d.pc    = pc;
      if_d.valid = 1'b1;
      if (!misaligned) if_d.inst = rom_inst;
    end
`ifdef INST_ALIGN_CHECK_EN
    if_d.excp_adel = rom_en_r & misaligned;
`endif
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk  (clk),
    .rst  (rst),
    .stall(stall),
    .flush(flush),
    .d    (if_d),
    .q    (if_q)
  );

  assign id_pc    = if_q.pc;
  assign id_inst  = if_q.inst;
  assign id_valid = if_q.valid;
`ifdef INST_ALIGN_CHECK_EN
  assign id_excp_adel = if_q.excp_adel;
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage: owns the PC, drives the instruction ROM's enable/address port, and registers the returned word into the IF/ID pipeline register.
- Initiator side of the ROM interface. The ROM is combinational, byte-addressed and big-endian, and returns the 32-bit word for `addr` in the same cycle.
- Handles sequential fetch, branch redirect (delay-slot semantics), pipeline stall, and exception flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset release.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_INST, 32'h0000_0000, word inserted into IF/ID on reset, flush or disabled fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and IF/ID contents.
- branch_flag  in  1  ID resolved a taken branch/jump this cycle.
- branch_target  in  `ADDR_BUS  redirect address for branch_flag.
- flush  in  1  exception/eret redirect from control.
- new_pc  in  `ADDR_BUS  redirect address for flush.
- rom_en  out  1  ROM chip enable (`CHIP_ENABLE` when fetching).
- rom_addr  out  `ADDR_BUS  current PC, driven straight from the PC register.
- rom_inst  in  `INST_BUS  word returned by the ROM.
- id_pc  out  `ADDR_BUS  PC of the instruction held in IF/ID.
- id_inst  out  `INST_BUS  instruction held in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc = RESET_PC; rom_en = disabled.
  - id_pc = 0, id_inst = NOP_INST, id_valid = 0.
- Enable ramp: rom_en is a register set to `CHIP_ENABLE` on the first rising edge after rst deasserts.
  - The PC does not advance while rom_en is disabled. The first fetch is therefore at RESET_PC, one cycle after release.
- rom_addr = pc at all times. rom_inst is sampled at the same edge that updates pc (zero-wait ROM).
- Next-PC priority, evaluated each edge while rom_en is enabled:
  1. flush: pc = new_pc.
  2. stall: pc holds.
  3. branch_flag: pc = branch_target.
  4. otherwise: pc = pc + PC_STEP.
- PC arithmetic is 32-bit; it wraps from 32'hFFFF_FFFC to 0 with no flag.
- IF/ID register, updated each edge:
  - flush: id_inst = NOP_INST, id_valid = 0, id_pc = 0.
  - else stall: all IF/ID fields hold.
  - else: id_pc = pc, id_inst = rom_inst, id_valid = 1 when rom_en is enabled. If rom_en is disabled, the register loads NOP_INST with id_valid = 0.
- Branch semantics (delay slot):
  - When branch_flag is asserted, the word fetched in that cycle (the delay slot) enters IF/ID normally.
  - Only the following fetch goes to branch_target.
  - branch_flag and branch_target are consumed only in non-stall cycles. ID must hold them stable across a stall.
- Simultaneous events:
  - flush with stall: flush wins and clears the stall effect for this block.
  - flush with branch: flush wins and the branch is dropped.
- Reset mid-operation: asynchronous return to reset values; no partial IF/ID content survives.
- No handshake on the ROM: one request per cycle, always accepted.

Optional Feature:
- Macro: INST_ALIGN_CHECK_EN.
- Defined:
  - Adds output id_excp_adel (1 bit), registered like id_valid.
  - The flag is set when the pc being fetched has pc[1:0] != 0.
  - For a misaligned pc, rom_en is deasserted for that cycle (combinationally gated), id_inst = NOP_INST, and id_valid = 1, so the exception reaches commit.
- Undefined:
  - No extra port.
  - Low address bits pass through to the ROM unchanged; behaviour for misaligned addresses is whatever the ROM returns.

Decomposition:
- Shared global definitions package holds:
  - `ADDR_BUS` and `INST_BUS`.
  - `CHIP_ENABLE` / `CHIP_DISABLE`.
  - `ZERO_WORD`.
  - NOP encoding and the reset vector.
- One natural sub-module: if_id_reg (IF/ID pipeline register with stall/flush priority), reused by later stage registers.
- The PC logic stays in inst_fetch.

Test Plan:
- Reset release:
  - rst low 3 cycles, then high → rom_en enabled after 1 edge.
  - rom_addr sequence 0,4,8,12.
  - id_inst matches the ROM word at each address one cycle later; id_valid=1 from the second enabled cycle.
- Stall at pc=8 held for 2 cycles → rom_addr stays 8 and id_pc/id_inst hold for 2 cycles, then resume 12.
- Branch: branch_flag=1, target=32'h40 while pc=0x10 → id gets the word at 0x10 (delay slot); next rom_addr=0x40, then 0x44.
- Flush with branch and stall all asserted, new_pc=32'h180 → next pc=0x180; id_valid=0, id_inst=NOP_INST; branch ignored.
- Mid-run asynchronous reset between edges → outputs return to reset values immediately; the PC restarts at RESET_PC.
- Alignment (INST_ALIGN_CHECK_EN defined): branch to 32'h42 → rom_en low that cycle; id_excp_adel=1, id_valid=1, id_inst=NOP_INST.
